// File: rtl/trap_monitor_mc.sv
// Multi-core trap/progress monitor: first trap per core plus a commit watchdog, queued as events.
// Latency trap->evt_valid is 2 cycles; sources stay pending while the event FIFO is full, none are dropped.

module trap_monitor_mc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] pushDat,
  input  logic         pop,
  output logic [W-1:0] headDat,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          doPush, doPop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign headDat = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushDat;
  end
endmodule

module trap_monitor_mc #(
  parameter int NCORES  = 2,
  parameter int PC_W    = 64,
  parameter int CW      = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 5000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCORES-1:0]      trap_valid,
  input  logic [32*NCORES-1:0]   trap_code,
  input  logic [PC_W*NCORES-1:0] trap_pc,
  input  logic [CW*NCORES-1:0]   commit_cnt,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic                   evt_kind,
  output logic [3:0]             evt_core,
  output logic [31:0]            evt_code,
  output logic [PC_W-1:0]        evt_pc,
  output logic [63:0]            evt_cycle,
  output logic [63:0]            evt_instr,
  output logic                   all_done,
  output logic                   timed_out
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic            kind;
    logic [3:0]      core;
    logic [31:0]     code;
    logic [PC_W-1:0] pc;
    logic [63:0]     cycle;
    logic [63:0]     instr;
  } evt_t;

  logic [63:0]       cycleCnt;
  logic [63:0]       instrCnt   [NCORES];
  logic [63:0]       nextInstr  [NCORES];
  evt_t              slot       [NCORES];
  evt_t              toSlot;
  logic [NCORES-1:0] trapped, pend;
  logic              pendTo, timedOut;
  logic [WDW-1:0]    wdCnt;
  logic [3:0]        rrPtr, grantIdx, nextRr;
  logic              coreGrant, doPush, takeCore, anyCommit;
  logic [63:0]       instrSum;
  evt_t              coreEntry, pushEntry, head, shown;
  logic              fifoEmpty, fifoFull;

  // Per-core instruction totals including this cycle's retirements
  always_comb begin
    anyCommit = 1'b0;
    instrSum  = '0;
    for (int k = 0; k < NCORES; k++) begin
      nextInstr[k] = instrCnt[k] + 64'(commit_cnt[k*CW +: CW]);
      instrSum     = instrSum + nextInstr[k];
      if (!trapped[k] && (commit_cnt[k*CW +: CW] != '0)) anyCommit = 1'b1;
    end
  end

  // Round-robin search: first pass from rrPtr upward, second pass wraps to 0
  always_comb begin
    coreGrant = 1'b0;
    grantIdx  = '0;
    coreEntry = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (!coreGrant && pend[k] && (k >= int'(rrPtr))) begin
        coreGrant = 1'b1;
        grantIdx  = 4'(k);
      end
    end
    for (int k = 0; k < NCORES; k++) begin
      if (!coreGrant && pend[k]) begin
        coreGrant = 1'b1;
        grantIdx  = 4'(k);
      end
    end
    for (int k = 0; k < NCORES; k++) begin
      if (grantIdx == 4'(k)) coreEntry = slot[k];
    end
    nextRr    = (int'(grantIdx) == NCORES - 1) ? 4'd0 : grantIdx + 4'd1;
    doPush    = ~fifoFull & (pendTo | coreGrant);
    takeCore  = doPush & ~pendTo;
    pushEntry = pendTo ? toSlot : coreEntry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt <= '0;
      trapped  <= '0;
      pend     <= '0;
      pendTo   <= 1'b0;
      timedOut <= 1'b0;
      wdCnt    <= '0;
      rrPtr    <= '0;
      toSlot   <= '0;
      for (int k = 0; k < NCORES; k++) begin
        instrCnt[k] <= '0;
        slot[k]     <= '0;
      end
    end else begin
      cycleCnt <= cycleCnt + 64'd1;
      for (int k = 0; k < NCORES; k++) begin
        instrCnt[k] <= nextInstr[k];
        if (trap_valid[k] && !trapped[k]) begin
          trapped[k] <= 1'b1;
          pend[k]    <= 1'b1;
          slot[k]    <= '{kind: 1'b0, core: 4'(k), code: trap_code[32*k +: 32],
                          pc: trap_pc[PC_W*k +: PC_W], cycle: cycleCnt, instr: nextInstr[k]};
        end else if (takeCore && (grantIdx == 4'(k))) begin
          pend[k] <= 1'b0;
        end
      end
      if (takeCore) rrPtr <= nextRr;
      if (doPush && pendTo) pendTo <= 1'b0;
      // One-shot timeout; the snapshot is taken in the cycle the threshold is seen
      if ((wdCnt == WDW'(TIMEOUT)) && !timedOut) begin
        timedOut <= 1'b1;
        pendTo   <= 1'b1;
        toSlot   <= '{kind: 1'b1, core: 4'd0, code: 32'd0, pc: '0,
                      cycle: cycleCnt, instr: instrSum};
      end
      if (timedOut || (&trapped) || anyCommit) wdCnt <= '0;
      else if (wdCnt != WDW'(TIMEOUT))         wdCnt <= wdCnt + 1'b1;
    end
  end

  trap_monitor_mc_fifo #(.W($bits(evt_t)), .DEPTH(DEPTH)) uFifo (
    .clk     (clk),
    .reset   (reset),
    .push    (doPush),
    .pushDat (pushEntry),
    .pop     (evt_ready),
    .headDat (head),
    .empty   (fifoEmpty),
    .full    (fifoFull)
  );

  assign shown     = fifoEmpty ? '0 : head;
  assign evt_valid = ~fifoEmpty;
  assign evt_kind  = shown.kind;
  assign evt_core  = shown.core;
  assign evt_code  = shown.code;
  assign evt_pc    = shown.pc;
  assign evt_cycle = shown.cycle;
  assign evt_instr = shown.instr;
  assign all_done  = (&trapped) & ~(|pend) & ~pendTo & fifoEmpty;
  assign timed_out = timedOut;
endmodule

// File: tb/tb_trap_monitor_mc.sv
// Directed bench for trap_monitor_mc with 4 cores, a 2-deep FIFO and a 16-cycle watchdog.
module tb_trap_monitor_mc;
  localparam int NC = 4;
  localparam int PW = 64;
  localparam int CWW = 3;
  localparam int DP = 2;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     trap_valid;
  logic [32*NC-1:0]  trap_code;
  logic [PW*NC-1:0]  trap_pc;
  logic [CWW*NC-1:0] commit_cnt;
  logic              evt_valid, evt_ready, evt_kind;
  logic [3:0]        evt_core;
  logic [31:0]       evt_code;
  logic [PW-1:0]     evt_pc;
  logic [63:0]       evt_cycle, evt_instr;
  logic              all_done, timed_out;

  int total = 0;
  int bad = 0;
  int seen;

  trap_monitor_mc #(.NCORES(NC), .PC_W(PW), .CW(CWW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_pc(trap_pc), .commit_cnt(commit_cnt), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_kind(evt_kind), .evt_core(evt_core),
    .evt_code(evt_code), .evt_pc(evt_pc), .evt_cycle(evt_cycle),
    .evt_instr(evt_instr), .all_done(all_done), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkEvt(input string tag, input logic [3:0] core, input logic [31:0] code,
                          input logic [63:0] pc, input logic [63:0] cyc, input logic [63:0] ins);
    chk({tag, ".valid"}, 64'(evt_valid), 64'd1);
    chk({tag, ".kind"},  64'(evt_kind),  64'd0);
    chk({tag, ".core"},  64'(evt_core),  64'(core));
    chk({tag, ".code"},  64'(evt_code),  64'(code));
    chk({tag, ".pc"},    evt_pc,         pc);
    chk({tag, ".cycle"}, evt_cycle,      cyc);
    chk({tag, ".instr"}, evt_instr,      ins);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clrIn();
    trap_valid = '0;
    trap_code  = '0;
    trap_pc    = '0;
    commit_cnt = '0;
  endtask

  task automatic setCommit(input int k, input int v);
    commit_cnt[k*CWW +: CWW] = CWW'(v);
  endtask

  task automatic setTrap(input int k, input logic [31:0] code, input logic [63:0] pc);
    trap_valid[k]        = 1'b1;
    trap_code[k*32 +: 32] = code;
    trap_pc[k*PW +: PW]   = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit exceeded total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    evt_ready = 1'b1;
    clrIn();
    tick();
    tick();
    chk("rst.valid", 64'(evt_valid), 64'd0);
    chk("rst.all_done", 64'(all_done), 64'd0);
    chk("rst.timed_out", 64'(timed_out), 64'd0);
    chk("rst.cycle", evt_cycle, 64'd0);
    reset = 1'b0;

    // Single trap on core 1 in cycle 10 after 7 prior commits
    for (int c = 0; c < 10; c++) begin
      clrIn();
      setCommit(1, (c < 7) ? 1 : 0);
      setCommit(2, 1);
      tick();
    end
    clrIn();
    setCommit(1, 1);
    setCommit(2, 1);
    setTrap(1, 32'd0, 64'h8000_1000);
    tick();
    clrIn();
    setCommit(2, 1);
    chk("t1.c11.valid", 64'(evt_valid), 64'd0);
    tick();
    checkEvt("t1", 4'd1, 32'd0, 64'h8000_1000, 64'd10, 64'd8);
    chk("t1.all_done", 64'(all_done), 64'd0);
    tick();
    chk("t1.popped", 64'(evt_valid), 64'd0);

    // Cycle 13: cores 0,2,3 trap together; rr pointer sits at 2 so order is 2,3,0
    clrIn();
    setCommit(2, 1);
    setCommit(0, 7);
    setCommit(3, 5);
    setTrap(0, 32'hA0, 64'h100);
    setTrap(2, 32'hC2, 64'h300);
    setTrap(3, 32'hD3, 64'h400);
    tick();
    clrIn();
    chk("t2.c14.valid", 64'(evt_valid), 64'd0);
    tick();
    checkEvt("t2.e0", 4'd2, 32'hC2, 64'h300, 64'd13, 64'd14);
    tick();
    checkEvt("t2.e1", 4'd3, 32'hD3, 64'h400, 64'd13, 64'd5);
    tick();
    checkEvt("t2.e2", 4'd0, 32'hA0, 64'h100, 64'd13, 64'd7);
    chk("t2.all_done_busy", 64'(all_done), 64'd0);
    tick();
    chk("t2.drained", 64'(evt_valid), 64'd0);
    chk("t2.all_done", 64'(all_done), 64'd1);

    // Repeat trap on core 0 must be ignored; watchdog idle while all trapped
    setTrap(0, 32'd1, 64'h999);
    tick();
    clrIn();
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (evt_valid) seen++;
      tick();
    end
    chk("t3.no_event", 64'(seen), 64'd0);
    chk("t3.all_done", 64'(all_done), 64'd1);
    chk("t3.no_timeout", 64'(timed_out), 64'd0);

    // Backpressure: all four trap, consumer stalls for cycles 0..19
    reset = 1'b1;
    #1;
    chk("t4.async_rst.all_done", 64'(all_done), 64'd0);
    tick();
    clrIn();
    evt_ready = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < NC; k++) begin
      setTrap(k, 32'(16 + k), 64'(4096 * (k + 1)));
      setCommit(k, k);
    end
    tick();
    clrIn();
    for (int c = 1; c < 5; c++) tick();
    checkEvt("t4.stall5", 4'd0, 32'h10, 64'h1000, 64'd0, 64'd0);
    for (int c = 5; c < 19; c++) tick();
    checkEvt("t4.stall19", 4'd0, 32'h10, 64'h1000, 64'd0, 64'd0);
    chk("t4.all_done_stall", 64'(all_done), 64'd0);
    tick();
    evt_ready = 1'b1;
    for (int k = 0; k < NC; k++) begin
      checkEvt($sformatf("t4.e%0d", k), 4'(k), 32'(16 + k), 64'(4096 * (k + 1)), 64'd0, 64'(k));
      tick();
    end
    chk("t4.drained", 64'(evt_valid), 64'd0);
    chk("t4.all_done", 64'(all_done), 64'd1);

    // Watchdog: last commit in cycle 5, event expected in cycle 24
    reset = 1'b1;
    tick();
    clrIn();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      setCommit(0, 1);
      tick();
    end
    clrIn();
    for (int c = 6; c < 22; c++) tick();
    chk("t5.c22.timed_out", 64'(timed_out), 64'd0);
    tick();
    chk("t5.c23.timed_out", 64'(timed_out), 64'd1);
    chk("t5.c23.valid", 64'(evt_valid), 64'd0);
    tick();
    chk("t5.valid", 64'(evt_valid), 64'd1);
    chk("t5.kind", 64'(evt_kind), 64'd1);
    chk("t5.core", 64'(evt_core), 64'd0);
    chk("t5.code", 64'(evt_code), 64'd0);
    chk("t5.pc", evt_pc, 64'd0);
    chk("t5.instr", evt_instr, 64'd6);
    tick();
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (evt_valid) seen++;
      tick();
    end
    chk("t5.no_repeat", 64'(seen), 64'd0);
    chk("t5.sticky", 64'(timed_out), 64'd1);
    chk("t5.all_done", 64'(all_done), 64'd0);

    // Reset while two events are queued
    reset = 1'b1;
    tick();
    clrIn();
    evt_ready = 1'b0;
    reset = 1'b0;
    chk("t6.timed_out_cleared", 64'(timed_out), 64'd0);
    setTrap(0, 32'h55, 64'h5000);
    setTrap(1, 32'h66, 64'h6000);
    tick();
    clrIn();
    tick();
    tick();
    chk("t6.queued.valid", 64'(evt_valid), 64'd1);
    chk("t6.queued.core", 64'(evt_core), 64'd0);
    #3;
    reset = 1'b1;
    #1;
    chk("t6.async.valid", 64'(evt_valid), 64'd0);
    chk("t6.async.code", 64'(evt_code), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    evt_ready = 1'b1;
    setTrap(2, 32'h77, 64'h7700);
    setCommit(2, 2);
    tick();
    clrIn();
    tick();
    checkEvt("t6.after", 4'd2, 32'h77, 64'h7700, 64'd0, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/trap_monitor_mc.md
# trap_monitor_mc

Simulation-side trap and progress monitor for multi-core builds. It captures the first good/bad trap from each of NCORES cores, together with the cycle count and that core's retired-instruction count. Captured events are queued in a small FIFO and presented on a valid/ready event port, which feeds the testbench reporting/DPI stage. A commit watchdog also reports a hang when no untrapped core retires instructions for TIMEOUT cycles.

## Interface
- NCORES, 2, number of monitored cores (1..16)
- PC_W, 64, trap PC width
- CW, 3, width of each per-core commit-count field
- DEPTH, 4, event FIFO depth (power of two, ≥2)
- TIMEOUT, 5000, watchdog threshold in cycles (≥2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- trap_valid  in  NCORES  bit k: core k signals trap this cycle
- trap_code  in  32*NCORES  trap code, core k in bits [32k+31:32k]
- trap_pc  in  PC_W*NCORES  trap PC, packed the same way
- commit_cnt  in  CW*NCORES  instructions retired by core k this cycle
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts the head
- evt_kind  out  1  0 = trap, 1 = watchdog timeout
- evt_core  out  4  core index (0 for timeout)
- evt_code  out  32  trap code (0 for timeout)
- evt_pc  out  PC_W  trap PC (0 for timeout)
- evt_cycle  out  64  cycle count at capture
- evt_instr  out  64  instruction count of evt_core at capture (sum of all cores for timeout)
- all_done  out  1  every core trapped and all events drained
- timed_out  out  1  sticky watchdog flag

## Operation
- cycle_cnt: 64-bit counter, 0 after reset, +1 every cycle, wraps modulo 2^64.
- instr_cnt[k]: 64-bit counter, adds the zero-extended commit_cnt[k] every cycle, wraps.
- Capture: trap_valid[k]=1 while trapped[k]=0 sets trapped[k] and pend[k], and loads a per-core slot with:
  - code and pc from the inputs;
  - cycle = cycle_cnt value in that cycle;
  - instr = instr_cnt[k] + commit_cnt[k] from that cycle.
- Later trap_valid[k] pulses are ignored until reset.
- Watchdog:
  - wd_cnt clears in any cycle where some untrapped core has nonzero commit_cnt.
  - It is held at 0 when all cores are trapped or timed_out=1.
  - Otherwise it increments, saturating at TIMEOUT.
  - When wd_cnt reaches TIMEOUT, timed_out and pend_to set on the next edge. This fires at most once.
- Arbitration: each cycle at most one pending source is pushed, and only if the FIFO is not full at cycle start.
  - pend_to has top priority.
  - Otherwise grant the lowest k ≥ rr_ptr with pend[k] set, wrapping. rr_ptr starts at 0 and becomes (granted k)+1 mod NCORES.
  - The granted pend bit clears.
  - No event is ever dropped; sources wait in their slots.
- FIFO: DEPTH entries. A pop occurs when evt_valid & evt_ready. The full check uses the occupancy at cycle start, so a pop does not free space for a push in the same cycle. A push and a pop in the same cycle leave occupancy unchanged.
- evt_* outputs show the FIFO head, registered. Payload is 0 when empty.
- all_done = all trapped bits, no pend bits, pend_to=0, FIFO empty.

## Timing
- Reset (async assert, sync deassert by the environment) sets all counters, trapped, pend, pend_to, timed_out, wd_cnt, rr_ptr and the FIFO pointers to 0. All outputs are 0 during and after reset until events occur.
- Latency: trap_valid in cycle t → pend at t+1 → pushed at the end of t+1 if granted → evt_valid=1 in t+2.
- Watchdog: the last commit in cycle t → evt_valid for the timeout in cycle t+TIMEOUT+3 with an empty FIFO.
- evt_* are stable while evt_valid=1 and evt_ready=0.
- Reset mid-operation discards queued and pending events immediately (asynchronously).

## Test plan
- Single trap:
  - Stimulus: NCORES=2; core 1 trap_valid at cycle 10 (cycle_cnt=10), code=0, pc=0x8000_1000; 7 prior commits plus commit_cnt=1 that cycle; evt_ready=1.
  - Response: evt_valid in cycle 12 with kind=0, core=1, code=0, pc=0x8000_1000, cycle=10, instr=8. all_done stays 0 until core 0 traps.
- Simultaneous traps:
  - Stimulus: both cores trap in the same cycle; evt_ready=1.
  - Response: core 0 event, then core 1 event on consecutive cycles. rr_ptr=0 afterwards. all_done=1 one cycle after the second pop.
- Repeat trap:
  - Stimulus: core 0 asserts trap_valid again with code=1.
  - Response: no second event; the first code is retained.
- Backpressure:
  - Stimulus: DEPTH=2, NCORES=4, all cores trap at once, evt_ready=0 for 20 cycles, then 1.
  - Response: the FIFO holds cores 0 and 1 while 2 and 3 stay pending. All four events then appear in order 0,1,2,3 with no loss and payload stable while stalled.
- Watchdog:
  - Stimulus: TIMEOUT=16, all commit_cnt=0 after cycle 5.
  - Response: timed_out=1 and exactly one kind=1 event. No repeat after 100 further idle cycles.
- Reset mid-run:
  - Stimulus: assert reset while 2 events are queued.
  - Response: evt_valid=0 immediately. After release, cycle_cnt restarts at 0 and a new trap is captured normally.
